// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with multi-word blocks, per-set
// round-robin replacement, whole-cache flush and hit/miss counters.
module icache_nway #(
    parameter int unsigned SETS          = 8,
    parameter int unsigned WAYS          = 2,
    parameter int unsigned WORDS_PER_BLK = 2,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [31:0]       imemload,
    input  logic              flush,
    output logic              flush_done,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned WB     = $clog2(WORDS_PER_BLK);
    localparam int unsigned IB     = $clog2(SETS);
    localparam int unsigned TB     = ADDR_W - 2 - WB - IB;
    localparam int unsigned WOFF_W = (WB > 0) ? WB : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Byte and word offset bits of a block; cleared to form the block base.
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS_PER_BLK * 4 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFlush
    } state_e;

    state_e state_q;

    // Storage
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] ptr_q   [SETS];
    logic [TB-1:0]    tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][WORDS_PER_BLK];

    // Fill / flush bookkeeping
    logic [ADDR_W-1:0] fill_base_q;
    logic [WAY_W-1:0]  victim_q;
    logic              all_valid_q;
    logic [WOFF_W-1:0] cnt_q;
    logic              pend_q;
    logic [IB-1:0]     set_cnt_q;
    logic [31:0]       hit_count_q;
    logic [31:0]       miss_count_q;

    // Request address fields
    logic [TB-1:0]     req_tag;
    logic [IB-1:0]     req_idx;
    logic [WOFF_W-1:0] req_woff;

    assign req_tag = imemaddr[ADDR_W-1 -: TB];
    assign req_idx = imemaddr[2+WB +: IB];

    generate
        if (WB > 0) begin : g_woff
            assign req_woff = imemaddr[2 +: WOFF_W];
        end else begin : g_no_woff
            assign req_woff = '0;
        end
    endgenerate

    // Latched fill fields, recovered from the block base address
    logic [TB-1:0] fill_tag;
    logic [IB-1:0] fill_idx;

    assign fill_tag = fill_base_q[ADDR_W-1 -: TB];
    assign fill_idx = fill_base_q[2+WB +: IB];

    logic              lookup;
    logic [WAYS-1:0]   way_match;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  first_inv;
    logic              all_valid;
    logic [WAY_W-1:0]  victim;
    logic              last_word;

    // Tag compare, hit-way and victim selection for the requested set
    always_comb begin
        way_match = '0;
        hit_way   = '0;
        first_inv = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_match[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
        end
        // Scan downward so the lowest-numbered way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                first_inv = WAY_W'(w);
            end
        end
        all_valid = &valid_q[req_idx];
        victim    = all_valid ? ptr_q[req_idx] : first_inv;
    end

    assign lookup    = (state_q == StIdle) && !flush && imemREN;
    assign ihit      = lookup && (|way_match);
    assign last_word = (cnt_q == WOFF_W'(WORDS_PER_BLK - 1));

    // Datapath-side and memory-side outputs
    always_comb begin
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        flush_done = 1'b0;
        if (ihit) begin
            imemload = data_q[req_idx][hit_way][req_woff];
        end
        if (state_q == StFill) begin
            iREN  = 1'b1;
            iaddr = fill_base_q + (ADDR_W'(cnt_q) << 2);
        end
        if ((state_q == StFlush) && (set_cnt_q == IB'(SETS - 1))) begin
            flush_done = 1'b1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Controller FSM: valid bits, victim pointers, counters and fill state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            fill_base_q  <= '0;
            victim_q     <= '0;
            all_valid_q  <= 1'b0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            set_cnt_q    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (ihit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        set_cnt_q <= '0;
                        state_q   <= StFlush;
                    end else if (imemREN && !(|way_match)) begin
                        fill_base_q  <= imemaddr & ~BLK_MASK;
                        victim_q     <= victim;
                        all_valid_q  <= all_valid;
                        cnt_q        <= '0;
                        miss_count_q <= miss_count_q + 32'd1;
                        // Invalidate now so a half-written block can never hit
                        valid_q[req_idx][victim] <= 1'b0;
                        state_q      <= StFill;
                    end
                end
                StFill: begin
                    if (flush) begin
                        pend_q <= 1'b1;
                    end
                    if (!iwait) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            valid_q[fill_idx][victim_q] <= 1'b1;
                            if (all_valid_q && (WAYS > 1)) begin
                                ptr_q[fill_idx] <= victim_q + 1'b1;
                            end
                            if (pend_q || flush) begin
                                set_cnt_q <= '0;
                                state_q   <= StFlush;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                StFlush: begin
                    valid_q[set_cnt_q] <= '0;
                    ptr_q[set_cnt_q]   <= '0;
                    set_cnt_q          <= set_cnt_q + 1'b1;
                    if (set_cnt_q == IB'(SETS - 1)) begin
                        pend_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Block tag and data writes; left unreset since valid bits gate every use
    always_ff @(posedge CLK) begin
        if ((state_q == StFill) && !iwait) begin
            data_q[fill_idx][victim_q][cnt_q] <= iload;
            if (last_word) begin
                tag_q[fill_idx][victim_q] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (8 sets, 2 ways, 2 words per block).
module tb_icache_nway;

    localparam int unsigned SETS = 8;
    localparam int unsigned WAYS = 2;
    localparam int unsigned WPB  = 2;
    localparam int unsigned AW   = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          imemREN;
    logic [AW-1:0] imemaddr;
    logic          ihit;
    logic [31:0]   imemload;
    logic          flush;
    logic          flush_done;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [31:0]   iload;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    always #5 CLK = ~CLK;

    icache_nway #(
        .SETS          (SETS),
        .WAYS          (WAYS),
        .WORDS_PER_BLK (WPB),
        .ADDR_W        (AW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .flush_done (flush_done),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboards: expected fetch data and expected memory read addresses
    logic [31:0] exp_data_q  [$];
    logic [31:0] exp_iaddr_q [$];

    int wait_cfg   = 0;
    int waits_left = 0;

    logic        s_ihit, s_iren, s_fd;
    logic [31:0] s_load, s_iaddr;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    vec_t vt [13];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, act as memory, then cross the edge
    task automatic tick();
        #1;
        s_ihit  = ihit;
        s_load  = imemload;
        s_iren  = iREN;
        s_iaddr = iaddr;
        s_fd    = flush_done;
        if (s_iren) begin
            if (waits_left > 0) begin
                iwait = 1'b1;
                waits_left--;
                if (exp_iaddr_q.size() != 0) begin
                    chk("iaddr_stable", s_iaddr, exp_iaddr_q[0]);
                end
            end else begin
                iwait = 1'b0;
                iload = mem(s_iaddr);
                waits_left = wait_cfg;
                if (exp_iaddr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_read: iaddr %h, required no read", s_iaddr);
                end else begin
                    chk("iaddr", s_iaddr, exp_iaddr_q.pop_front());
                end
            end
        end else begin
            iwait = 1'b0;
            iload = 32'hDEAD_BEEF;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Issue a fetch and hold it until ihit; checks data, latency and reads
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input string name);
        int lat;
        int exp_lat;
        bit got;
        exp_lat = exp_hit ? 0 : 1 + int'(WPB) * (1 + wait_cfg);
        if (!exp_hit) begin
            for (int k = 0; k < int'(WPB); k++) begin
                exp_iaddr_q.push_back((a & ~32'(WPB * 4 - 1)) + 32'(4 * k));
            end
        end
        exp_data_q.push_back(mem(a));
        imemREN    = 1'b1;
        imemaddr   = a;
        waits_left = wait_cfg;
        got        = 1'b0;
        lat        = 0;
        while (!got && lat < 100) begin
            tick();
            if (s_ihit) begin
                got = 1'b1;
                chk({name, "_data"}, s_load, exp_data_q.pop_front());
                chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
            end else begin
                lat++;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no ihit within %0d cycles, required %0d", name, lat, exp_lat);
            exp_data_q.delete();
        end
        imemREN = 1'b0;
        chk({name, "_reads"}, 32'(exp_iaddr_q.size()), 32'd0);
        exp_iaddr_q.delete();
    endtask

    initial begin
        int fd_at;

        vt[0]  = '{32'h0000_0040, 1'b0};  // cold miss, set 0 way 0
        vt[1]  = '{32'h0000_0044, 1'b1};  // other word of the same block
        vt[2]  = '{32'h0000_0080, 1'b0};  // same set, way 1
        vt[3]  = '{32'h0000_0040, 1'b1};
        vt[4]  = '{32'h0000_0084, 1'b1};
        vt[5]  = '{32'h0000_00C0, 1'b0};  // third tag evicts way 0 (0x40)
        vt[6]  = '{32'h0000_0080, 1'b1};
        vt[7]  = '{32'h0000_0040, 1'b0};  // re-fetch misses, evicts 0x80
        vt[8]  = '{32'h0000_00C4, 1'b1};
        vt[9]  = '{32'h0000_0048, 1'b0};  // set 1
        vt[10] = '{32'h0000_004C, 1'b1};
        vt[11] = '{32'h0000_0080, 1'b0};  // round robin back to way 0
        vt[12] = '{32'h0000_0044, 1'b1};

        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b0;
        iload    = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);

        for (int i = 0; i < 13; i++) begin
            fetch(vt[i].addr, vt[i].hit, $sformatf("vec%0d", i));
        end
        chk("table_hits", hit_count, 32'd13);
        chk("table_misses", miss_count, 32'd6);

        // Three wait cycles before each word
        wait_cfg = 3;
        fetch(32'h0000_0208, 1'b0, "wait_miss");
        wait_cfg = 0;
        fetch(32'h0000_020C, 1'b1, "wait_hit");
        chk("wait_hits", hit_count, 32'd15);
        chk("wait_misses", miss_count, 32'd7);

        // Flush from IDLE with a hitting request present
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        flush    = 1'b1;
        tick();
        chk("flush_nohit", 32'(s_ihit), 32'd0);
        flush   = 1'b0;
        imemREN = 1'b0;
        fd_at   = -1;
        for (int c = 1; c <= 30 && fd_at < 0; c++) begin
            tick();
            if (s_fd) fd_at = c;
        end
        chk("flush_lat", 32'(fd_at), 32'd8);
        tick();
        chk("flush_done_pulse", 32'(s_fd), 32'd0);
        chk("flush_counts", miss_count, 32'd7);
        fetch(32'h0000_0040, 1'b0, "post_flush");

        // Flush raised during FILL: fill completes, then the walk
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        exp_iaddr_q.push_back(32'h0000_0080);
        exp_iaddr_q.push_back(32'h0000_0084);
        waits_left = 0;
        tick();
        chk("mf_c0_nohit", 32'(s_ihit), 32'd0);
        imemREN = 1'b0;
        flush   = 1'b1;
        tick();
        chk("mf_c1_iren", 32'(s_iren), 32'd1);
        flush = 1'b0;
        fd_at = -1;
        for (int c = 2; c <= 40 && fd_at < 0; c++) begin
            tick();
            if (s_fd) fd_at = c;
        end
        chk("mf_flush_lat", 32'(fd_at), 32'd10);
        chk("mf_reads", 32'(exp_iaddr_q.size()), 32'd0);
        exp_iaddr_q.delete();
        fetch(32'h0000_0080, 1'b0, "mf_refetch");

        // Request address changes while the fill is in flight
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        exp_iaddr_q.push_back(32'h0000_0040);
        exp_iaddr_q.push_back(32'h0000_0044);
        tick();
        imemaddr = 32'h0000_0100;
        tick();
        chk("ac_c1_nohit", 32'(s_ihit), 32'd0);
        chk("ac_c1_load_zero", s_load, 32'd0);
        tick();
        chk("ac_c2_nohit", 32'(s_ihit), 32'd0);
        chk("ac_reads", 32'(exp_iaddr_q.size()), 32'd0);
        exp_iaddr_q.delete();
        fetch(32'h0000_0100, 1'b0, "ac_new_addr");
        fetch(32'h0000_0040, 1'b1, "ac_latched_block");
        chk("ac_hits", hit_count, 32'd19);
        chk("ac_misses", miss_count, 32'd12);

        // Reset in cycle 1 of a miss
        imemREN  = 1'b1;
        imemaddr = 32'h0000_00C0;
        exp_iaddr_q.push_back(32'h0000_00C0);
        exp_iaddr_q.push_back(32'h0000_00C4);
        tick();
        RST = 1'b1;
        tick();
        chk("rf_c1_iren", 32'(s_iren), 32'd1);
        RST     = 1'b0;
        imemREN = 1'b0;
        exp_iaddr_q.delete();
        #1;
        chk("rf_iren_off", 32'(iREN), 32'd0);
        chk("rf_iaddr_zero", iaddr, 32'd0);
        chk("rf_hit_count", hit_count, 32'd0);
        chk("rf_miss_count", miss_count, 32'd0);
        fetch(32'h0000_0040, 1'b0, "rf_refetch");
        chk("rf_final_misses", miss_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
